// File: rtl/lcd_text_scheduler_pkg.sv
// Shared definitions for the Text LCD line scheduler: character geometry,
// the blank code, FSM state encodings and the character-code sanitiser.
package lcd_pkg;

  localparam int CHAR_W    = 5;
  localparam int NUM_CHARS = 8;
  localparam int LINE_W    = CHAR_W * NUM_CHARS;
  localparam int LEN_W     = 4;

  localparam logic [CHAR_W-1:0] CH_SPACE  = 5'd31;
  localparam logic [CHAR_W-1:0] CH_LAST_Z = 5'd25;
  localparam logic [LEN_W-1:0]  LEN_FULL  = 4'd8;

  typedef enum logic [0:0] {
    S_TEXT = 1'b0,
    S_MSG  = 1'b1
  } state_t;

  // Codes 26..30 have no glyph on the driver; they are shown as a blank.
  function automatic logic [CHAR_W-1:0] sanitize_char(input logic [CHAR_W-1:0] code);
    logic [CHAR_W-1:0] result;
    if (code > CH_LAST_Z) begin
      result = CH_SPACE;
    end else begin
      result = code;
    end
    return result;
  endfunction

endpackage

// File: rtl/lcd_text_scheduler_if.sv
// Bundle of the character/message strobes and the LCD-facing outputs.
// master = Morse decoder / status logic side, slave = scheduler side.
interface lcd_text_scheduler_if;
  import lcd_pkg::*;

  logic                   iChar_vld;
  logic [CHAR_W-1:0]      iChar;
  logic                   iBksp;
  logic                   iClear;
  logic                   iMsg_req;
  logic [LINE_W-1:0]      iMsg_data;
  logic                   oMsg_ack;
  logic [LINE_W-1:0]      oCharData;
  logic                   oMsg_mode;
  logic [LEN_W-1:0]       oLen;

  modport master (
    output iChar_vld, iChar, iBksp, iClear, iMsg_req, iMsg_data,
    input  oMsg_ack, oCharData, oMsg_mode, oLen
  );

  modport slave (
    input  iChar_vld, iChar, iBksp, iClear, iMsg_req, iMsg_data,
    output oMsg_ack, oCharData, oMsg_mode, oLen
  );

endinterface

// File: rtl/lcd_text_scheduler_line_buffer.sv
// Eight-slot text line: clear / backspace / append with left scroll when full.
// Exposes the next-state line so the parent can register it without extra latency.
module lcd_line_buffer
  import lcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 bksp,
  input  logic                 append,
  input  logic [CHAR_W-1:0]    code,
  output logic [LINE_W-1:0]    line_nxt,
  output logic [LEN_W-1:0]     len
);

  logic [CHAR_W-1:0] slots     [NUM_CHARS];
  logic [CHAR_W-1:0] slots_nxt [NUM_CHARS];
  logic [LEN_W-1:0]  len_nxt;
  logic [2:0]        last_idx;

  // Slot being removed by a backspace; wraps 8 -> 7 through the 3-bit field.
  assign last_idx = len[2:0] - 3'd1;

  // Next-state line: clear beats backspace beats append.
  always_comb begin
    slots_nxt = slots;
    len_nxt   = len;
    if (clear) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        slots_nxt[i] = CH_SPACE;
      end
      len_nxt = 4'd0;
    end else if (bksp) begin
      if (len != 4'd0) begin
        slots_nxt[last_idx] = CH_SPACE;
        len_nxt             = len - 4'd1;
      end else begin
        len_nxt = 4'd0;
      end
    end else if (append) begin
      if (len < LEN_FULL) begin
        slots_nxt[len[2:0]] = code;
        len_nxt             = len + 4'd1;
      end else begin
        for (int i = 0; i < NUM_CHARS - 1; i++) begin
          slots_nxt[i] = slots[i+1];
        end
        slots_nxt[NUM_CHARS-1] = code;
        len_nxt                = LEN_FULL;
      end
    end else begin
      len_nxt = len;
    end
  end

  // Pack next-state slots for the driver bus, char 0 in the low bits.
  always_comb begin
    line_nxt = '1;
    for (int i = 0; i < NUM_CHARS; i++) begin
      line_nxt[i*CHAR_W +: CHAR_W] = slots_nxt[i];
    end
  end

  // Slot and length storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        slots[i] <= CH_SPACE;
      end
      len <= 4'd0;
    end else begin
      slots <= slots_nxt;
      len   <= len_nxt;
    end
  end

endmodule

// File: rtl/lcd_text_scheduler.sv
// Text LCD line owner: live Morse text line, pre-empted by status messages
// that are held on the display for HOLD_CYCLES clocks.
module lcd_text_scheduler
  import lcd_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  lcd_text_scheduler_if.slave   bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [LINE_W-1:0] msg_reg, msg_nxt;
  logic              msg_ack, msg_ack_nxt;
  logic [LINE_W-1:0] line_nxt;
  logic [LINE_W-1:0] char_data;
  logic [LEN_W-1:0]  line_len;

  lcd_line_buffer u_line (
    .clk      (iCLK),
    .rst      (iRST),
    .clear    (bus.iClear),
    .bksp     (bus.iBksp),
    .append   (bus.iChar_vld),
    .code     (sanitize_char(bus.iChar)),
    .line_nxt (line_nxt),
    .len      (line_len)
  );

  // Message FSM: accept requests, space re-acks by a cycle, count the hold time.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    msg_nxt      = msg_reg;
    msg_ack_nxt  = 1'b0;
    case (state)
      S_TEXT: begin
        if (bus.iMsg_req) begin
          msg_nxt      = bus.iMsg_data;
          msg_ack_nxt  = 1'b1;
          hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
          state_nxt    = S_MSG;
        end else begin
          state_nxt = S_TEXT;
        end
      end
      S_MSG: begin
        if (bus.iMsg_req && !msg_ack) begin
          msg_nxt      = bus.iMsg_data;
          msg_ack_nxt  = 1'b1;
          hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
          state_nxt    = S_MSG;
        end else if (hold_cnt == '0) begin
          state_nxt = S_TEXT;
        end else begin
          hold_cnt_nxt = hold_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = S_TEXT;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, hold counter, latched message and ack pulse.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= S_TEXT;
      hold_cnt <= '0;
      msg_reg  <= '1;
      msg_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      msg_reg  <= msg_nxt;
      msg_ack  <= msg_ack_nxt;
    end
  end

  // Driver bus register, fed from next-state values so every event shows one cycle later.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      char_data <= 40'hFF_FFFF_FFFF;
    end else if (state_nxt == S_MSG) begin
      char_data <= msg_nxt;
    end else begin
      char_data <= line_nxt;
    end
  end

  assign bus.oCharData = char_data;
  assign bus.oMsg_ack  = msg_ack;
  assign bus.oMsg_mode = (state == S_MSG);
  assign bus.oLen      = line_len;

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Directed bench for lcd_text_scheduler with a 16-cycle message hold.
module tb_lcd_text_scheduler;

  localparam int HOLD = 16;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   hold_count;

  lcd_text_scheduler_if bus();

  lcd_text_scheduler #(.HOLD_CYCLES(HOLD), .CNT_W(5)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [39:0] pack8(input logic [4:0] c0, input logic [4:0] c1,
                                        input logic [4:0] c2, input logic [4:0] c3,
                                        input logic [4:0] c4, input logic [4:0] c5,
                                        input logic [4:0] c6, input logic [4:0] c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs sampled at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge iCLK);
    #1;
    bus.iChar_vld = 1'b0;
    bus.iBksp     = 1'b0;
    bus.iClear    = 1'b0;
  endtask

  task automatic send_char(input logic [4:0] code);
    bus.iChar     = code;
    bus.iChar_vld = 1'b1;
    step();
  endtask

  task automatic send_msg(input logic [39:0] data);
    bus.iMsg_req  = 1'b1;
    bus.iMsg_data = data;
    step();
    bus.iMsg_req  = 1'b0;
  endtask

  // Counts further cycles with oMsg_mode high, bounded so a stuck FSM cannot hang the run.
  task automatic count_hold(inout int cnt);
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.oMsg_mode !== 1'b1) break;
      cnt++;
    end
  endtask

  logic [39:0] msg_err, msg_a, msg_b, msg_c, msg_d, blank;

  initial begin
    msg_err = pack8(5'd4, 5'd17, 5'd17, 5'd14, 5'd17, 5'd31, 5'd31, 5'd31);
    msg_a   = pack8(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    msg_b   = pack8(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8);
    msg_c   = pack8(5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17);
    msg_d   = pack8(5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd31, 5'd0);
    blank   = 40'hFF_FFFF_FFFF;

    bus.iChar_vld = 1'b0;
    bus.iChar     = 5'd0;
    bus.iBksp     = 1'b0;
    bus.iClear    = 1'b0;
    bus.iMsg_req  = 1'b0;
    bus.iMsg_data = 40'd0;

    // 1. reset values
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_data", bus.oCharData, blank);
    chk("rst_len",  40'(bus.oLen), 40'd0);
    chk("rst_mode", 40'(bus.oMsg_mode), 40'd0);
    chk("rst_ack",  40'(bus.oMsg_ack), 40'd0);
    iRST = 1'b0;
    step();

    // 2. append A,B,C then an unmapped code shown as blank
    send_char(5'd0);
    send_char(5'd1);
    send_char(5'd2);
    chk("abc_data", bus.oCharData, pack8(5'd0, 5'd1, 5'd2, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31));
    chk("abc_len",  40'(bus.oLen), 40'd3);
    send_char(5'd27);
    chk("c27_data", bus.oCharData, pack8(5'd0, 5'd1, 5'd2, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31));
    chk("c27_len",  40'(bus.oLen), 40'd4);

    // 3. clear, nine chars A..I (one scroll), backspace
    bus.iClear = 1'b1;
    step();
    chk("clr_len", 40'(bus.oLen), 40'd0);
    for (int i = 0; i < 9; i++) send_char(5'(i));
    chk("scroll_data", bus.oCharData, pack8(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8));
    chk("scroll_len",  40'(bus.oLen), 40'd8);
    bus.iBksp = 1'b1;
    step();
    chk("bksp_data", bus.oCharData, pack8(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31));
    chk("bksp_len",  40'(bus.oLen), 40'd7);

    // 4. ERROR message held 16 cycles; X,Y typed meanwhile
    send_msg(msg_err);
    chk("msg_ack",  40'(bus.oMsg_ack), 40'd1);
    chk("msg_mode", 40'(bus.oMsg_mode), 40'd1);
    chk("msg_data", bus.oCharData, msg_err);
    hold_count = 1;
    send_char(5'd23);
    chk("ack_pulse", 40'(bus.oMsg_ack), 40'd0);
    if (bus.oMsg_mode === 1'b1) hold_count++;
    send_char(5'd24);
    if (bus.oMsg_mode === 1'b1) hold_count++;
    chk("msg_hides_line", bus.oCharData, msg_err);
    chk("len_during_msg", 40'(bus.oLen), 40'd8);
    count_hold(hold_count);
    chk("hold1", 40'(hold_count), 40'd16);
    chk("post_msg_mode", 40'(bus.oMsg_mode), 40'd0);
    chk("post_msg_data", bus.oCharData, pack8(5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd23, 5'd24));

    // 5a. pre-empt at hold count 3 restarts the full hold
    send_msg(msg_a);
    repeat (12) step();
    chk("preA_mode", 40'(bus.oMsg_mode), 40'd1);
    send_msg(msg_b);
    chk("preB_ack",  40'(bus.oMsg_ack), 40'd1);
    chk("preB_data", bus.oCharData, msg_b);
    hold_count = 1;
    count_hold(hold_count);
    chk("hold2", 40'(hold_count), 40'd16);

    // 5b. request in the expiry cycle keeps the message mode
    send_msg(msg_c);
    repeat (15) step();
    chk("expC_mode", 40'(bus.oMsg_mode), 40'd1);
    send_msg(msg_d);
    chk("expD_mode", 40'(bus.oMsg_mode), 40'd1);
    chk("expD_ack",  40'(bus.oMsg_ack), 40'd1);
    chk("expD_data", bus.oCharData, msg_d);
    hold_count = 1;
    count_hold(hold_count);
    chk("hold3", 40'(hold_count), 40'd16);

    // 6a. clear + bksp + char in one cycle: clear wins
    bus.iClear    = 1'b1;
    bus.iBksp     = 1'b1;
    bus.iChar     = 5'd5;
    bus.iChar_vld = 1'b1;
    step();
    chk("prio_data", bus.oCharData, blank);
    chk("prio_len",  40'(bus.oLen), 40'd0);

    // 6b. reset pulse during a message
    send_char(5'd3);
    send_msg(msg_c);
    step();
    iRST = 1'b1;
    #1;
    chk("mid_rst_data", bus.oCharData, blank);
    chk("mid_rst_len",  40'(bus.oLen), 40'd0);
    chk("mid_rst_mode", 40'(bus.oMsg_mode), 40'd0);
    chk("mid_rst_ack",  40'(bus.oMsg_ack), 40'd0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    step();
    chk("after_rst_mode", 40'(bus.oMsg_mode), 40'd0);
    chk("after_rst_data", bus.oCharData, blank);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
